fifo_rd_arb: RTL and testbench

FIFO_RD_ARB -- requirements
Module: fifo_rd_arb

---
 rtl/fifo_arb_pkg.sv | 18 +
 rtl/arb_rr_pick.sv | 32 +++
 rtl/fifo_rd_arb.sv | 142 ++++++++++++++
 tb/tb_fifo_rd_arb.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_arb_pkg.sv
// Shared types and defaults for the FIFO read arbiter.
package fifo_arb_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_e;

  localparam int DEF_DATESIZE  = 17;
  localparam int DEF_NUM_CH    = 4;
  localparam int DEF_BURST_LEN = 4;

  // Increment with wrap at n (round-robin pointer advance).
  function automatic int wrap_inc(input int v, input int n);
    return (v + 1 >= n) ? 0 : v + 1;
  endfunction

endpackage

// File: rtl/arb_rr_pick.sv
// Combinational round-robin picker: first asserted request at or after
// ptr_i, wrapping from NUM_CH-1 back to 0.
module arb_rr_pick #(
  parameter int NUM_CH = 4,
  parameter int CH_W   = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req_i,
  input  logic [CH_W-1:0]   ptr_i,
  output logic [CH_W-1:0]   grant_o,
  output logic              valid_o
);

  int              idx;
  logic [CH_W-1:0] idx_w;

  // Scan from the pointer outwards; the first hit wins.
  always_comb begin
    grant_o = '0;
    valid_o = 1'b0;
    idx     = 0;
    idx_w   = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      idx   = (int'(ptr_i) + i) % NUM_CH;
      idx_w = CH_W'(idx);
      if (!valid_o && req_i[idx_w]) begin
        valid_o = 1'b1;
        grant_o = idx_w;
      end
    end
  end

endmodule

// File: rtl/fifo_rd_arb.sv
// FIFO read-port arbiter: grants one fall-through FIFO at a time and pops up
// to BURST_LEN words into a registered valid/ready output stage.
// Optional macro FIFO_ARB_PRIO0_EN: channel 0 takes strict priority at each
// arbitration; remaining channels are served round-robin.
module fifo_rd_arb
  import fifo_arb_pkg::*;
#(
  parameter int DATESIZE  = DEF_DATESIZE,
  parameter int NUM_CH    = DEF_NUM_CH,
  parameter int BURST_LEN = DEF_BURST_LEN,
  parameter int CH_W      = $clog2(NUM_CH),
  parameter int CNT_W     = $clog2(BURST_LEN + 1)
) (
  input  logic                       rclk,
  input  logic                       rrst_n,
  input  logic [NUM_CH-1:0]          rempty,
  input  logic [NUM_CH*DATESIZE-1:0] rdata,
  output logic [NUM_CH-1:0]          ren,
  output logic [DATESIZE-1:0]        out_data,
  output logic [CH_W-1:0]            out_ch,
  output logic                       out_last,
  output logic                       out_valid,
  input  logic                       out_ready
);

  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(BURST_LEN);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BURST_LEN - 1);

  arb_state_e          state_q;
  logic [CH_W-1:0]     rr_ptr_q;
  logic [CH_W-1:0]     grant_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [DATESIZE-1:0] out_data_q;
  logic [CH_W-1:0]     out_ch_q;
  logic                out_last_q;
  logic                out_valid_q;

  logic [NUM_CH-1:0]   req;
  logic [CH_W-1:0]     pick_idx;
  logic                pick_vld;
  logic [CH_W-1:0]     sel_d;
  logic                sel_vld_d;
  logic                pop;
  logic [DATESIZE-1:0] head_data;
  logic [CH_W-1:0]     next_ptr;

  // Requests entering the round-robin pool.
  always_comb begin
    req = ~rempty;
`ifdef FIFO_ARB_PRIO0_EN
    req[0] = 1'b0;
`endif
  end

  arb_rr_pick #(
    .NUM_CH (NUM_CH),
    .CH_W   (CH_W)
  ) u_pick (
    .req_i   (req),
    .ptr_i   (rr_ptr_q),
    .grant_o (pick_idx),
    .valid_o (pick_vld)
  );

  // Final arbitration choice, with channel 0 override when enabled.
  always_comb begin
    sel_d     = pick_idx;
    sel_vld_d = pick_vld;
`ifdef FIFO_ARB_PRIO0_EN
    if (!rempty[0]) begin
      sel_d     = '0;
      sel_vld_d = 1'b1;
    end
`endif
  end

  assign head_data = rdata[int'(grant_q)*DATESIZE +: DATESIZE];
  assign next_ptr  = CH_W'(wrap_inc(int'(grant_q), NUM_CH));

  // Pop strobe: granted FIFO has data, burst budget left, output slot free.
  always_comb begin
    pop = (state_q == BURST) && !rempty[grant_q] && (cnt_q < CNT_MAX) &&
          (!out_valid_q || out_ready);
    ren = '0;
    if (pop) begin
      ren[grant_q] = 1'b1;
    end
  end

  // Arbitration FSM, burst counter and registered output stage.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      grant_q     <= '0;
      cnt_q       <= '0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
      out_last_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      if (pop) begin
        out_data_q  <= head_data;
        out_ch_q    <= grant_q;
        out_valid_q <= 1'b1;
        out_last_q  <= (cnt_q == CNT_LAST);
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
      end

      case (state_q)
        IDLE: begin
          if (sel_vld_d) begin
            grant_q <= sel_d;
            cnt_q   <= '0;
            state_q <= BURST;
          end
        end
        BURST: begin
          if (pop) begin
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == CNT_LAST) begin
              state_q  <= IDLE;
              rr_ptr_q <= next_ptr;
            end
          end else if (rempty[grant_q]) begin
            // Source ran dry: end the burst early, last word stays unmarked.
            state_q  <= IDLE;
            rr_ptr_q <= next_ptr;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;
  assign out_last  = out_last_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_fifo_rd_arb.sv
// Directed bench for fifo_rd_arb with four modelled fall-through FIFOs.
module tb_fifo_rd_arb;

  localparam int DS  = 17;
  localparam int NCH = 4;
  localparam int BL  = 4;

  logic              rclk = 1'b0;
  logic              rrst_n;
  logic [NCH-1:0]    rempty;
  logic [NCH*DS-1:0] rdata;
  logic [NCH-1:0]    ren;
  logic [DS-1:0]     out_data;
  logic [1:0]        out_ch;
  logic              out_last;
  logic              out_valid;
  logic              out_ready;

  int total = 0;
  int bad   = 0;

  always #5 rclk = ~rclk;

  fifo_rd_arb #(
    .DATESIZE  (DS),
    .NUM_CH    (NCH),
    .BURST_LEN (BL)
  ) dut (
    .rclk      (rclk),
    .rrst_n    (rrst_n),
    .rempty    (rempty),
    .rdata     (rdata),
    .ren       (ren),
    .out_data  (out_data),
    .out_ch    (out_ch),
    .out_last  (out_last),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  // FIFO models: write side from the stimulus, read side popped by ren.
  logic [DS-1:0] mem [NCH][256];
  int wr_cnt [NCH];
  int rd_cnt [NCH];

  always @(posedge rclk) begin
    for (int k = 0; k < NCH; k++) begin
      if (ren[k]) rd_cnt[k] <= rd_cnt[k] + 1;
    end
  end

  for (genvar k = 0; k < NCH; k++) begin : g_fifo
    assign rempty[k]          = (wr_cnt[k] == rd_cnt[k]);
    assign rdata[k*DS +: DS]  = mem[k][rd_cnt[k][7:0]];
  end

  // Output capture of every accepted transfer.
  int            cyc = 0;
  logic [DS-1:0] cap_data [1024];
  logic [1:0]    cap_ch   [1024];
  logic          cap_last [1024];
  int            cap_cyc  [1024];
  int            cap_n = 0;

  always @(posedge rclk) cyc <= cyc + 1;

  always @(negedge rclk) begin
    if (rrst_n && out_valid && out_ready && cap_n < 1024) begin
      cap_data[cap_n] <= out_data;
      cap_ch[cap_n]   <= out_ch;
      cap_last[cap_n] <= out_last;
      cap_cyc[cap_n]  <= cyc;
      cap_n           <= cap_n + 1;
    end
  end

  task automatic push(input int ch, input int n, input int first);
    logic [7:0] a;
    for (int i = 0; i < n; i++) begin
      a = 8'((wr_cnt[ch] + i) % 256);
      mem[ch][a] = DS'(ch * 4096 + first + i);
    end
    wr_cnt[ch] = wr_cnt[ch] + n;
  endtask

  // Enter reset, empty every FIFO, leave reset asserted.
  task automatic apply_reset();
    rrst_n    = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < NCH; k++) wr_cnt[k] = rd_cnt[k];
    @(posedge rclk);
    #1;
  endtask

  task automatic wait_caps(input int base, input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(posedge rclk);
      #1;
      if (cap_n - base >= n) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rrst_n    = 1'b1;
    out_ready = 1'b1;
    #2;
    rrst_n = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", out_valid); end
    total++; if (out_data !== '0) begin bad++; $display("FAIL reset_data got=%h want=0", out_data); end
    total++; if (out_ch !== 2'd0) begin bad++; $display("FAIL reset_ch got=%0d want=0", out_ch); end
    total++; if (out_last !== 1'b0) begin bad++; $display("FAIL reset_last got=%b want=0", out_last); end
    total++; if (ren !== 4'b0000) begin bad++; $display("FAIL reset_ren got=%b want=0000", ren); end
  endtask

  // Ten words on ch1: bursts 4,4,2, last on words 4 and 8, one bubble between.
  task automatic test_single_ch();
    int base;
    bit ok;
    int gap;
    int exp_gap;
    logic [DS-1:0] exp_d;
    logic exp_l;
    apply_reset();
    push(1, 10, 0);
    base   = cap_n;
    rrst_n = 1'b1;
    wait_caps(base, 10, 200, ok);
    total++; if (!ok) begin bad++; $display("FAIL single_timeout got=%0d want=10", cap_n - base); end
    for (int j = 0; j < 10; j++) begin
      exp_d = DS'(4096 + j);
      exp_l = (j == 3) || (j == 7);
      total++;
      if (cap_data[base+j] !== exp_d || cap_ch[base+j] !== 2'd1 || cap_last[base+j] !== exp_l) begin
        bad++;
        $display("FAIL single_word%0d got=%h/%0d/%b want=%h/1/%b", j, cap_data[base+j], cap_ch[base+j], cap_last[base+j], exp_d, exp_l);
      end
    end
    for (int j = 1; j < 10; j++) begin
      gap     = cap_cyc[base+j] - cap_cyc[base+j-1];
      exp_gap = (j == 4 || j == 8) ? 2 : 1;
      total++;
      if (gap !== exp_gap) begin bad++; $display("FAIL single_gap%0d got=%0d want=%0d", j, gap, exp_gap); end
    end
  endtask

  // All four channels with eight words each.
  task automatic test_round_robin();
    int base;
    bit ok;
    int order [8];
    int seen [NCH];
    int b;
    int ch;
    int seq;
    logic [DS-1:0] exp_d;
    logic exp_l;
`ifdef FIFO_ARB_PRIO0_EN
    order = '{0, 0, 1, 2, 3, 1, 2, 3};
`else
    order = '{0, 1, 2, 3, 0, 1, 2, 3};
`endif
    for (int k = 0; k < NCH; k++) seen[k] = 0;
    apply_reset();
    for (int k = 0; k < NCH; k++) push(k, 8, 0);
    base   = cap_n;
    rrst_n = 1'b1;
    wait_caps(base, 32, 300, ok);
    total++; if (!ok) begin bad++; $display("FAIL rr_timeout got=%0d want=32", cap_n - base); end
    for (int j = 0; j < 32; j++) begin
      b     = j / 4;
      ch    = order[b];
      seq   = seen[ch] * 4 + (j % 4);
      exp_d = DS'(ch * 4096 + seq);
      exp_l = ((j % 4) == 3);
      if ((j % 4) == 3) seen[ch]++;
      total++;
      if (cap_data[base+j] !== exp_d || cap_ch[base+j] !== 2'(ch) || cap_last[base+j] !== exp_l) begin
        bad++;
        $display("FAIL rr_word%0d got=%h/%0d/%b want=%h/%0d/%b", j, cap_data[base+j], cap_ch[base+j], cap_last[base+j], exp_d, ch, exp_l);
      end
    end
  endtask

  // Five-cycle stall while the third word of a ch2 burst sits in the output.
  task automatic test_backpressure();
    int base;
    bit ok;
    logic [DS-1:0] exp_d;
    apply_reset();
    push(2, 8, 0);
    base   = cap_n;
    rrst_n = 1'b1;
    wait_caps(base, 2, 100, ok);
    total++; if (!ok) begin bad++; $display("FAIL bp_start_timeout got=%0d want=2", cap_n - base); end
    out_ready = 1'b0;
    for (int s = 0; s < 5; s++) begin
      @(negedge rclk);
      total++;
      if (out_valid !== 1'b1 || out_data !== DS'(2 * 4096 + 2) || ren !== 4'b0000) begin
        bad++;
        $display("FAIL bp_hold%0d got=%b/%h/%b want=1/%h/0000", s, out_valid, out_data, ren, DS'(2 * 4096 + 2));
      end
    end
    @(posedge rclk);
    #1;
    out_ready = 1'b1;
    wait_caps(base, 8, 100, ok);
    total++; if (!ok) begin bad++; $display("FAIL bp_timeout got=%0d want=8", cap_n - base); end
    repeat (10) @(posedge rclk);
    #1;
    total++; if (cap_n - base !== 8) begin bad++; $display("FAIL bp_count got=%0d want=8", cap_n - base); end
    for (int j = 0; j < 8; j++) begin
      exp_d = DS'(2 * 4096 + j);
      total++;
      if (cap_data[base+j] !== exp_d || cap_ch[base+j] !== 2'd2 || cap_last[base+j] !== (j == 3 || j == 7)) begin
        bad++;
        $display("FAIL bp_word%0d got=%h/%0d/%b want=%h/2/%b", j, cap_data[base+j], cap_ch[base+j], cap_last[base+j], exp_d, (j == 3 || j == 7));
      end
    end
  endtask

  // Reset while the second ch3 word is held; ch1 refilled during reset wins after.
  task automatic test_reset_mid();
    int base;
    bit ok;
    int exp_ch [7];
    int exp_sq [7];
    logic exp_l;
    logic [DS-1:0] exp_d;
    exp_ch = '{1, 1, 1, 3, 3, 3, 3};
    exp_sq = '{0, 1, 2, 2, 3, 4, 5};
    apply_reset();
    push(3, 6, 0);
    base   = cap_n;
    rrst_n = 1'b1;
    wait_caps(base, 1, 100, ok);
    total++; if (!ok) begin bad++; $display("FAIL rmid_start_timeout got=%0d want=1", cap_n - base); end
    total++; if (out_valid !== 1'b1 || out_data !== DS'(3 * 4096 + 1)) begin bad++; $display("FAIL rmid_pre got=%b/%h want=1/%h", out_valid, out_data, DS'(3 * 4096 + 1)); end
    rrst_n = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rmid_valid got=%b want=0", out_valid); end
    total++; if (out_data !== '0) begin bad++; $display("FAIL rmid_data got=%h want=0", out_data); end
    total++; if (out_ch !== 2'd0) begin bad++; $display("FAIL rmid_ch got=%0d want=0", out_ch); end
    total++; if (out_last !== 1'b0) begin bad++; $display("FAIL rmid_last got=%b want=0", out_last); end
    total++; if (ren !== 4'b0000) begin bad++; $display("FAIL rmid_ren got=%b want=0000", ren); end
    push(1, 3, 0);
    @(posedge rclk);
    #1;
    base   = cap_n;
    rrst_n = 1'b1;
    wait_caps(base, 7, 100, ok);
    total++; if (!ok) begin bad++; $display("FAIL rmid_timeout got=%0d want=7", cap_n - base); end
    for (int j = 0; j < 7; j++) begin
      exp_d = DS'(exp_ch[j] * 4096 + exp_sq[j]);
      exp_l = (j == 6);
      total++;
      if (cap_data[base+j] !== exp_d || cap_ch[base+j] !== 2'(exp_ch[j]) || cap_last[base+j] !== exp_l) begin
        bad++;
        $display("FAIL rmid_word%0d got=%h/%0d/%b want=%h/%0d/%b", j, cap_data[base+j], cap_ch[base+j], cap_last[base+j], exp_d, exp_ch[j], exp_l);
      end
    end
  endtask

  // ch0 and ch2 never run dry: priority build always grants ch0.
  task automatic test_prio();
    int base;
    bit ok;
    int ch;
    int seq;
    logic [DS-1:0] exp_d;
    apply_reset();
    push(0, 40, 0);
    push(2, 40, 0);
    base   = cap_n;
    rrst_n = 1'b1;
    wait_caps(base, 24, 200, ok);
    total++; if (!ok) begin bad++; $display("FAIL prio_timeout got=%0d want=24", cap_n - base); end
    for (int b = 0; b < 6; b++) begin
`ifdef FIFO_ARB_PRIO0_EN
      ch  = 0;
      seq = b * 4;
`else
      ch  = (b % 2 == 0) ? 0 : 2;
      seq = (b / 2) * 4;
`endif
      exp_d = DS'(ch * 4096 + seq);
      total++;
      if (cap_ch[base+b*4] !== 2'(ch) || cap_data[base+b*4] !== exp_d) begin
        bad++;
        $display("FAIL prio_burst%0d got=%0d/%h want=%0d/%h", b, cap_ch[base+b*4], cap_data[base+b*4], ch, exp_d);
      end
    end
  endtask

  initial begin
    for (int k = 0; k < NCH; k++) begin
      wr_cnt[k] = 0;
    end
    test_reset();
    test_single_ch();
    test_round_robin();
    test_backpressure();
    test_reset_mid();
    test_prio();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
